// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the writeback stage: widths, load funct3
// encodings and the writeback state encoding.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bus between execute/memory and the writeback stage, including the
// regfile write port and status outputs.
interface wb_stage_if
  import rv32_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic                  wb_i_valid;
  logic                  wb_o_ready;
  logic [REG_ADDR_W-1:0] wb_i_rd;
  logic                  wb_i_is_load;
  logic [2:0]            wb_i_funct3;
  logic [XLEN-1:0]       wb_i_alu_result;
  logic                  wb_i_mem_rvalid;
  logic [XLEN-1:0]       wb_i_mem_rdata;
  logic [REG_ADDR_W-1:0] wb_o_rf_write_reg;
  logic [XLEN-1:0]       wb_o_rf_write_data;
  logic                  wb_o_err;
  logic [CNT_W-1:0]      wb_o_retire_cnt;

  modport master (
    output wb_i_valid, wb_i_rd, wb_i_is_load, wb_i_funct3, wb_i_alu_result,
           wb_i_mem_rvalid, wb_i_mem_rdata,
    input  wb_o_ready, wb_o_rf_write_reg, wb_o_rf_write_data, wb_o_err,
           wb_o_retire_cnt
  );

  modport slave (
    input  wb_i_valid, wb_i_rd, wb_i_is_load, wb_i_funct3, wb_i_alu_result,
           wb_i_mem_rvalid, wb_i_mem_rdata,
    output wb_o_ready, wb_o_rf_write_reg, wb_o_rf_write_data, wb_o_err,
           wb_o_retire_cnt
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: selects byte/halfword from an aligned word,
// extends it, and flags misaligned or illegal load encodings.
module load_align
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  output logic [XLEN-1:0] data,
  output logic            bad
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    bad  = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   begin
        data = {{(XLEN-16){half_sel[15]}}, half_sel};
        bad  = addr[0];
      end
      F3_LHU:  begin
        data = {{(XLEN-16){1'b0}}, half_sel};
        bad  = addr[0];
      end
      F3_LW:   bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage in front of the register file (write_reg = 0 means no write).
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
)(
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);

  wb_state_t             state;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]       write_data;
  logic                  err;
  logic [CNT_W-1:0]      retire_cnt;

  logic [REG_ADDR_W-1:0] rd_p0;
  logic [2:0]            funct3_p0;
  logic [1:0]            addr_p0;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_bad;
  logic                  ready;
  logic                  accept;

  assign ready  = (state != WB_WAIT_MEM);
  assign accept = bus.wb_i_valid && ready;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

  load_align u_align (
    .rdata  (bus.wb_i_mem_rdata),
    .funct3 (funct3_p0),
    .addr   (addr_p0),
    .data   (ld_data),
    .bad    (ld_bad)
  );

  // Load context captured at accept; the misalign/illegal decision depends
  // only on these fields, so it is fixed from the accept cycle onward.
  always_ff @(posedge clk) begin
    if (accept && bus.wb_i_is_load) begin
      rd_p0     <= bus.wb_i_rd;
      funct3_p0 <= bus.wb_i_funct3;
      addr_p0   <= bus.wb_i_alu_result[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WB_IDLE;
      write_reg  <= '0;
      write_data <= '0;
      err        <= 1'b0;
      retire_cnt <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      err       <= 1'b0;
      write_reg <= '0;
      case (state)
        WB_IDLE, WB_WRITE: begin
          if (state == WB_WRITE) retire_cnt <= retire_cnt + CNT_W'(1);
          if (accept) begin
            if (bus.wb_i_is_load) begin
              state <= WB_WAIT_MEM;
`ifdef WB_LOAD_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state      <= WB_WRITE;
              write_reg  <= bus.wb_i_rd;
              write_data <= bus.wb_i_alu_result;
            end
          end else begin
            state <= WB_IDLE;
          end
        end
        WB_WAIT_MEM: begin
          if (bus.wb_i_mem_rvalid) begin
            if (ld_bad) begin
              err        <= 1'b1;
              retire_cnt <= retire_cnt + CNT_W'(1);
              state      <= WB_IDLE;
            end else begin
              write_reg  <= rd_p0;
              write_data <= ld_data;
              state      <= WB_WRITE;
            end
          end
`ifdef WB_LOAD_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err        <= 1'b1;
            retire_cnt <= retire_cnt + CNT_W'(1);
            state      <= WB_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  assign bus.wb_o_ready         = ready;
  assign bus.wb_o_rf_write_reg  = write_reg;
  assign bus.wb_o_rf_write_data = write_data;
  assign bus.wb_o_err           = err;
  assign bus.wb_o_retire_cnt    = retire_cnt;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the 32x32 register file.
- Accepts completed ALU results and load requests from the execute/memory stage, and waits for the data-memory response on loads.
- Extracts and extends load bytes/halfwords, then drives the regfile write port.
- The regfile has no write enable: this block drives write-reg = 0 on every cycle with no write.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles WAIT_MEM may last before abort (used only with the optional feature).
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_i_valid  in  1  upstream presents an instruction.
- wb_o_ready  out  1  stage can accept; transfer when valid && ready.
- wb_i_rd  in  5  destination register.
- wb_i_is_load  in  1  1 = load, wait for memory response.
- wb_i_funct3  in  3  load width/sign (RV32I encoding).
- wb_i_alu_result  in  32  ALU result; for loads, the byte address.
- wb_i_mem_rvalid  in  1  memory read data valid (single-cycle pulse).
- wb_i_mem_rdata  in  32  aligned memory word.
- wb_o_rf_write_reg  out  5  to regfile write-reg; 0 = no write.
- wb_o_rf_write_data  out  32  to regfile write-data.
- wb_o_err  out  1  one-cycle pulse: bad funct3, misaligned load, or timeout.
- wb_o_retire_cnt  out  CNT_W  instructions retired (writes plus rd=0 ops plus errored ops).

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; write_reg=0; write_data=0; err=0; retire_cnt=0.
  - wb_o_ready=1 once reset releases.
- State machine with states IDLE, WAIT_MEM, WRITE:
  - IDLE: ready=1.
    - On accept of a non-load: latch rd and result, go to WRITE.
    - On accept of a load: latch rd, funct3 and addr[1:0], go to WAIT_MEM.
  - WAIT_MEM: ready=0.
    - On rvalid: format the data and latch it, go to WRITE.
    - rvalid in the same cycle as the load's accept is ignored; minimum memory latency is 1 cycle.
  - WRITE: write_reg/write_data registered outputs hold the value for exactly one cycle, then return to IDLE.
    - ready=1 in WRITE: a new accept in WRITE goes directly to the next state (WRITE or WAIT_MEM), giving back-to-back ALU ops one write per cycle.
- Latency:
  - ALU op accepted in cycle N is written in cycle N+1.
  - Load whose rvalid arrives in cycle M is written in cycle M+1.
- Outputs in non-WRITE cycles: write_reg=0; write_data holds its last value.
- rd=0: still retired, but write_reg stays 0.
- Load formatting, using latched funct3 and addr[1:0]:
  - 000 LB: sign-extend byte[addr].
  - 100 LBU: zero-extend byte[addr].
  - 001 LH: sign-extend half[addr[1]].
  - 101 LHU: zero-extend half[addr[1]].
  - 010 LW: full word.
  - 011, 110, 111: no write, err pulse, retire.
- Misalignment: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, gives no write, err pulse and retire.
  - The check is done at accept; the stage still waits for rvalid to drain the response.
- rvalid while in IDLE or WRITE is ignored.
- retire_cnt increments by 1 on each transition out of WRITE or error completion, and wraps at 2^CNT_W.
- Reset asserted mid-WAIT_MEM aborts the load; a late rvalid after reset is ignored.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle.
  - Reaching TIMEOUT_CYCLES without rvalid gives an err pulse, no write, retire, and return to IDLE.
- Undefined: WAIT_MEM waits indefinitely; no counter logic exists.

Decomposition:
- Shared package rv32_pkg:
  - funct3 load encodings: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb state encoding.
  - XLEN=32 and REG_ADDR_W=5.
- Sub-module load_align: purely combinational; inputs rdata, funct3, addr[1:0]; outputs formatted data and a misalign/illegal flag.

Test Plan:
- ALU op, rd=5, result 0xDEADBEEF, accepted cycle 10 -> write_reg=5, write_data=0xDEADBEEF in cycle 11 only; retire_cnt=1.
- LB, addr 0x...03, rdata 0x80FF_FF_FF, rvalid 3 cycles later -> write_data=0xFFFFFF80; ready=0 throughout WAIT_MEM. LBU on the same stimulus -> 0x00000080.
- LH, addr 0x...02, rdata 0x8001_1234 -> 0xFFFF8001; LW at addr 0x...02 -> err pulse, write_reg stays 0, retire_cnt increments after rvalid.
- Four back-to-back ALU ops, rd=1,2,0,3 -> writes on 4 consecutive cycles with write_reg 1, 2, 0, 3; retire_cnt=4.
- rst pulled low in WAIT_MEM, rvalid arrives after release -> no write, state IDLE, outputs 0.
- With WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rvalid -> err after 8 WAIT_MEM cycles, ready=1 the next cycle.
